// File: rtl/bisr_repair_cam.sv
// Built-in self-repair remap CAM: maps BIST-failed words onto spare flops.
// Optional define BISR_DUP_FILTER_EN drops fail reports already in the table.
module bisr_repair_cam #(
    parameter  int ADDR_W  = 16,
    parameter  int DATA_W  = 8,
    parameter  int N_SPARE = 4,
    localparam int CNT_W   = $clog2(N_SPARE + 1),
    localparam int IDX_W   = (N_SPARE > 1) ? $clog2(N_SPARE) : 1
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              FAIL_VLD,
    input  logic [ADDR_W-1:0] FAIL_ADDR,
    input  logic              BIST_DONE,
    input  logic              REPAIR_CLR,
    input  logic              ACC_EN,
    input  logic              ACC_WE,
    input  logic [ADDR_W-1:0] ACC_ADDR,
    input  logic [DATA_W-1:0] ACC_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              MEM_EN,
    output logic [DATA_W-1:0] ACC_RDATA,
    output logic              ACC_HIT_Q,
    output logic [CNT_W-1:0]  REPAIR_CNT,
    output logic              REPAIR_OVF,
    output logic              REPAIR_OK
);

    typedef enum logic {
        S_COLLECT,
        S_LOCKED
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [N_SPARE-1:0] valid_q;
    logic [ADDR_W-1:0]  tag_q  [N_SPARE];
    logic [DATA_W-1:0]  data_q [N_SPARE];
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               hit_q;
    logic [DATA_W-1:0]  spare_q;

    logic               hit_any;
    logic [IDX_W-1:0]   hit_idx;
    logic               free_any;
    logic [IDX_W-1:0]   free_idx;
    logic               full;
    logic               fail_dup;
    logic               fail_take;
    logic               alloc;
    logic               ovf_set;
    logic               wr_hit;

    // Access lookup: lowest-index valid entry whose tag equals the address
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = N_SPARE - 1; i >= 0; i--) begin
            if (ACC_EN && valid_q[i] && (tag_q[i] == ACC_ADDR)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Allocation target: lowest invalid entry
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = N_SPARE - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef BISR_DUP_FILTER_EN
    // Duplicate detect: fail address already owns a valid entry
    always_comb begin
        fail_dup = 1'b0;
        for (int i = 0; i < N_SPARE; i++) begin
            if (valid_q[i] && (tag_q[i] == FAIL_ADDR)) begin
                fail_dup = 1'b1;
            end
        end
    end
`else
    assign fail_dup = 1'b0;
`endif

    assign full      = (cnt_q == CNT_W'(N_SPARE)) || !free_any;
    assign fail_take = FAIL_VLD && (state_q == S_COLLECT)
                       && !REPAIR_CLR && !fail_dup;
    assign alloc     = fail_take && !full;
    assign ovf_set   = fail_take && full;
    assign wr_hit    = hit_any && ACC_WE;

    assign MEM_EN     = ACC_EN && !hit_any;
    assign ACC_RDATA  = hit_q ? spare_q : MEM_RDATA;
    assign ACC_HIT_Q  = hit_q;
    assign REPAIR_CNT = cnt_q;
    assign REPAIR_OVF = ovf_q;
    assign REPAIR_OK  = (state_q == S_LOCKED) && !ovf_q;

    // Next state: clear wins over BIST completion
    always_comb begin
        state_d = state_q;
        if (REPAIR_CLR) begin
            state_d = S_COLLECT;
        end else if ((state_q == S_COLLECT) && BIST_DONE) begin
            state_d = S_LOCKED;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Repair table: allocation, clear and write-hit data update
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            valid_q <= '0;
            for (int i = 0; i < N_SPARE; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (REPAIR_CLR) begin
            valid_q <= '0;
        end else begin
            if (alloc) begin
                valid_q[free_idx] <= 1'b1;
                tag_q[free_idx]   <= FAIL_ADDR;
                data_q[free_idx]  <= '0;
            end
            if (wr_hit) begin
                data_q[hit_idx] <= ACC_WDATA;
            end
        end
    end

    // Allocation count and sticky overflow flag
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (REPAIR_CLR) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (alloc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Read return stage aligned with the macro's one-cycle latency
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            hit_q   <= 1'b0;
            spare_q <= '0;
        end else begin
            hit_q <= hit_any;
            if (hit_any) begin
                spare_q <= data_q[hit_idx];
            end
        end
    end

endmodule

// File: tb/tb_bisr_repair_cam.sv
// Bench for bisr_repair_cam: directed scenarios then random traffic
// checked against a queue-based repair table model.
module tb_bisr_repair_cam;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int CW = $clog2(NS + 1);

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          FAIL_VLD = 1'b0;
    logic [AW-1:0] FAIL_ADDR = '0;
    logic          BIST_DONE = 1'b0;
    logic          REPAIR_CLR = 1'b0;
    logic          ACC_EN = 1'b0;
    logic          ACC_WE = 1'b0;
    logic [AW-1:0] ACC_ADDR = '0;
    logic [DW-1:0] ACC_WDATA = '0;
    logic [DW-1:0] MEM_RDATA;
    logic          MEM_EN;
    logic [DW-1:0] ACC_RDATA;
    logic          ACC_HIT_Q;
    logic [CW-1:0] REPAIR_CNT;
    logic          REPAIR_OVF;
    logic          REPAIR_OK;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bisr_repair_cam #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .N_SPARE(NS)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .FAIL_VLD  (FAIL_VLD),
        .FAIL_ADDR (FAIL_ADDR),
        .BIST_DONE (BIST_DONE),
        .REPAIR_CLR(REPAIR_CLR),
        .ACC_EN    (ACC_EN),
        .ACC_WE    (ACC_WE),
        .ACC_ADDR  (ACC_ADDR),
        .ACC_WDATA (ACC_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .MEM_EN    (MEM_EN),
        .ACC_RDATA (ACC_RDATA),
        .ACC_HIT_Q (ACC_HIT_Q),
        .REPAIR_CNT(REPAIR_CNT),
        .REPAIR_OVF(REPAIR_OVF),
        .REPAIR_OK (REPAIR_OK)
    );

    // SRAM macro stand-in, driven only by what the DUT forwards
    logic [DW-1:0] macro_mem [int];
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            MEM_RDATA <= '0;
        end else if (MEM_EN) begin
            if (ACC_WE) begin
                macro_mem[int'(ACC_ADDR)] = ACC_WDATA;
            end else begin
                MEM_RDATA <= macro_mem.exists(int'(ACC_ADDR))
                             ? macro_mem[int'(ACC_ADDR)] : '0;
            end
        end
    end

    // Reference model: entries in allocation order
    logic [AW-1:0] m_tags [$];
    logic [DW-1:0] m_data [$];
    logic [DW-1:0] m_mem  [int];
    bit            m_locked;
    bit            m_ovf;

    function automatic int m_find(logic [AW-1:0] a);
        for (int i = 0; i < m_tags.size(); i++)
            if (m_tags[i] == a) return i;
        return -1;
    endfunction

    function automatic logic [DW-1:0] m_rd(logic [AW-1:0] a);
        return m_mem.exists(int'(a)) ? m_mem[int'(a)] : '0;
    endfunction

    task automatic m_reset();
        m_tags.delete();
        m_data.delete();
        m_locked = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit fv, logic [AW-1:0] fa, bit done, bit clr,
                        bit en, bit we, logic [AW-1:0] addr,
                        logic [DW-1:0] wd);
        int            idx;
        bit            ehit;
        bit            dup;
        logic [DW-1:0] erd;
        FAIL_VLD   = fv;
        FAIL_ADDR  = fa;
        BIST_DONE  = done;
        REPAIR_CLR = clr;
        ACC_EN     = en;
        ACC_WE     = we;
        ACC_ADDR   = addr;
        ACC_WDATA  = wd;
        #1;
        idx  = en ? m_find(addr) : -1;
        ehit = (idx >= 0);
        chk("mem_en", MEM_EN, en && !ehit);
        erd = ehit ? m_data[idx] : m_rd(addr);
        @(posedge CLK);
        #1;
        if (en && we) begin
            if (ehit) m_data[idx] = wd;
            else m_mem[int'(addr)] = wd;
        end
        if (clr) begin
            m_reset();
        end else if (!m_locked) begin
            if (fv) begin
                dup = 1'b0;
`ifdef BISR_DUP_FILTER_EN
                dup = (m_find(fa) >= 0);
`endif
                if (!dup) begin
                    if (m_tags.size() == NS) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_tags.push_back(fa);
                        m_data.push_back('0);
                    end
                end
            end
            if (done) m_locked = 1'b1;
        end
        chk("hit_q", ACC_HIT_Q, ehit);
        if (en && !we) chk("rdata", ACC_RDATA, erd);
        chk("cnt", REPAIR_CNT, m_tags.size());
        chk("ovf", REPAIR_OVF, m_ovf);
        chk("ok", REPAIR_OK, m_locked && !m_ovf);
    endtask

    task automatic fail(logic [AW-1:0] a);
        step(1, a, 0, 0, 0, 0, '0, '0);
    endtask
    task automatic bdone();
        step(0, '0, 1, 0, 0, 0, '0, '0);
    endtask
    task automatic rclr();
        step(0, '0, 0, 1, 0, 0, '0, '0);
    endtask
    task automatic wr(logic [AW-1:0] a, logic [DW-1:0] d);
        step(0, '0, 0, 0, 1, 1, a, d);
    endtask
    task automatic rd(logic [AW-1:0] a);
        step(0, '0, 0, 0, 1, 0, a, '0);
    endtask

    initial begin
        int r;
        m_reset();
        @(posedge CLK);
        #1;
        chk("rst_mem_en", MEM_EN, 0);
        chk("rst_rdata", ACC_RDATA, 0);
        chk("rst_hit_q", ACC_HIT_Q, 0);
        chk("rst_cnt", REPAIR_CNT, 0);
        chk("rst_ovf", REPAIR_OVF, 0);
        chk("rst_ok", REPAIR_OK, 0);
        #2 RSTN = 1'b1;
        @(posedge CLK);
        #1;

        fail(16'hF658);
        fail(16'hECC8);
        fail(16'hDA58);
        bdone();
        chk("t1_cnt", REPAIR_CNT, 3);
        chk("t1_ok", REPAIR_OK, 1);
        wr(16'hECC8, 8'hA5);
        rd(16'hECC8);
        chk("t1_rd", ACC_RDATA, 8'hA5);
        chk("t1_hit", ACC_HIT_Q, 1);
        fail(16'h1234);
        chk("locked_ignore", REPAIR_CNT, 3);

        wr(16'h0010, 8'h3C);
        rd(16'h0010);
        chk("miss_rd", ACC_RDATA, 8'h3C);
        chk("miss_hit", ACC_HIT_Q, 0);

        rclr();
        for (int i = 0; i < 5; i++) fail(16'h0200 + 16'(i));
        bdone();
        chk("ovf_cnt", REPAIR_CNT, 4);
        chk("ovf_flag", REPAIR_OVF, 1);
        chk("ovf_ok", REPAIR_OK, 0);
        rclr();
        chk("clr_cnt", REPAIR_CNT, 0);
        chk("clr_ovf", REPAIR_OVF, 0);
        step(1, 16'h0300, 0, 1, 0, 0, '0, '0);
        chk("clr_drops_fail", REPAIR_CNT, 0);

        fail(16'h002E);
        fail(16'h002E);
`ifdef BISR_DUP_FILTER_EN
        chk("dup_cnt", REPAIR_CNT, 1);
`else
        chk("dup_cnt", REPAIR_CNT, 2);
`endif
        wr(16'h002E, 8'h77);
        rd(16'h002E);
        chk("dup_rd", ACC_RDATA, 8'h77);

        step(1, 16'h0034, 0, 0, 1, 0, 16'h0034, '0);
        chk("same_cyc_hit", ACC_HIT_Q, 0);
        rd(16'h0034);
        chk("next_hit", ACC_HIT_Q, 1);
        chk("next_rd", ACC_RDATA, 8'h00);

        ACC_EN   = 1'b1;
        ACC_WE   = 1'b0;
        ACC_ADDR = 16'h0034;
        FAIL_VLD = 1'b0;
        @(posedge CLK);
        #1;
        chk("pre_rst_hit", ACC_HIT_Q, 1);
        RSTN = 1'b0;
        #1;
        chk("async_hit_q", ACC_HIT_Q, 0);
        chk("async_cnt", REPAIR_CNT, 0);
        ACC_EN = 1'b0;
        m_reset();
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        rd(16'h0034);
        chk("post_rst_hit", ACC_HIT_Q, 0);

        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            step($urandom_range(0, 9) < 3,
                 16'h0100 + 16'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 5,
                 r < 3,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 1) == 1,
                 16'h0100 + 16'($urandom_range(0, 7)),
                 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
